// File: rtl/blob_frame_feeder.sv
// Thresholds an RGB camera frame into a 1-bit image, stores it on chip,
// then replays it as a gap-free raster stream for the blob counter.
module blob_frame_feeder #(
    parameter int IMG_COL = 800,
    parameter int IMG_ROW = 600,
    parameter int PIX_W   = 12,
    parameter int INVERT  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_fval,
    input  logic             i_dval,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    input  logic [PIX_W-1:0] i_thresh,
    input  logic             i_done,
    output logic             o_valid,
    output logic             o_seq,
    output logic             o_busy,
    output logic             o_err
);

    localparam int N      = IMG_COL * IMG_ROW;
    localparam int ADDR_W = 19;
    localparam int AW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] N_A  = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] N1_A = ADDR_W'(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAP,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  thr_q, thr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              fval_q;
    logic              rd_vld_q, rd_vld_d;
    logic              valid_q, valid_d;
    logic              seq_q, seq_d;
    logic              rd_bit_q;
    logic              we;
    logic [PIX_W+1:0]  sum;
    logic [PIX_W-1:0]  luma;
    logic              fg;

    logic mem [2**AW];

    // Luma approximation and foreground decision; equality is background.
    always_comb begin
        sum  = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
        luma = PIX_W'(sum >> 2);
        fg   = (INVERT != 0) ? (luma < thr_q) : (luma > thr_q);
    end

    // Next-state, counters and stream pipeline control.
    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        err_d     = err_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rd_vld_d  = 1'b0;
        valid_d   = valid_q;
        seq_d     = rd_vld_q & rd_bit_q;
        we        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (i_start) begin
                    thr_d     = i_thresh;
                    err_d     = 1'b0;
                    wr_addr_d = '0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (i_fval && !fval_q) begin
                    state_d = S_CAP;
                    if (i_dval) begin
                        we        = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            S_CAP: begin
                if (!i_fval) begin
                    if (wr_addr_q == N_A) begin
                        rd_addr_d = '0;
                        state_d   = S_STREAM;
                    end else begin
                        err_d     = 1'b1;
                        wr_addr_d = '0;
                        state_d   = S_ARM;
                    end
                end else if (i_dval && (wr_addr_q < N_A)) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            S_STREAM: begin
                valid_d   = 1'b1;
                rd_vld_d  = (rd_addr_q < N_A);
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q == N1_A) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                valid_d = 1'b1;
                if (i_done) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            thr_q     <= '0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            fval_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            valid_q   <= 1'b0;
            seq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_q     <= thr_d;
            err_q     <= err_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            fval_q    <= i_fval;
            rd_vld_q  <= rd_vld_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
        end
    end

    // Frame memory: 1-bit write port, synchronous read port.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[wr_addr_q[AW-1:0]] <= fg;
        end
        rd_bit_q <= mem[rd_addr_q[AW-1:0]];
    end

    assign o_valid = valid_q;
    assign o_seq   = seq_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_err   = err_q;

endmodule

// File: tb/tb_blob_frame_feeder.sv
// Randomized self-checking bench for blob_frame_feeder, 8x4 frames,
// with one instance per foreground polarity sharing the same stimulus.
module tb_blob_frame_feeder;

    localparam int COL = 8;
    localparam int ROW = 4;
    localparam int N   = COL * ROW;
    localparam int PW  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fval = 1'b0;
    logic          dval = 1'b0;
    logic [PW-1:0] r = '0;
    logic [PW-1:0] g = '0;
    logic [PW-1:0] b = '0;
    logic [PW-1:0] thresh = '0;
    logic          done = 1'b0;
    logic          valid1, seq1, busy1, err1;
    logic          valid0, seq0, busy0, err0;

    int checks = 0;
    int errors = 0;

    int pr[64];
    int pg[64];
    int pb[64];
    bit exp1[N];
    bit exp0[N];
    int cur_thr;

    blob_frame_feeder #(
        .IMG_COL(COL), .IMG_ROW(ROW), .PIX_W(PW), .INVERT(1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_fval(fval), .i_dval(dval),
        .i_r(r), .i_g(g), .i_b(b), .i_thresh(thresh),
        .i_done(done),
        .o_valid(valid1), .o_seq(seq1), .o_busy(busy1), .o_err(err1)
    );

    blob_frame_feeder #(
        .IMG_COL(COL), .IMG_ROW(ROW), .PIX_W(PW), .INVERT(0)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_fval(fval), .i_dval(dval),
        .i_r(r), .i_g(g), .i_b(b), .i_thresh(thresh),
        .i_done(done),
        .o_valid(valid0), .o_seq(seq0), .o_busy(busy0), .o_err(err0)
    );

    always #5 clk = ~clk;

    function automatic bit model_bit(int rr, int gg, int bb, int thr, bit inv);
        int luma;
        luma = ((rr + 2 * gg + bb) / 4) % 4096;
        if (inv) return (luma < thr);
        return (luma > thr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            pr[i] = $urandom_range(4095);
            pg[i] = $urandom_range(4095);
            pb[i] = $urandom_range(4095);
        end
    endtask

    task automatic calc_exp();
        for (int k = 0; k < N; k++) begin
            exp1[k] = model_bit(pr[k], pg[k], pb[k], cur_thr, 1'b1);
            exp0[k] = model_bit(pr[k], pg[k], pb[k], cur_thr, 1'b0);
        end
    endtask

    task automatic do_start(input int thr);
        cur_thr = thr;
        start   = 1'b1;
        thresh  = PW'(thr);
        step();
        start   = 1'b0;
        thresh  = PW'($urandom_range(4095));
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got %b want 1", busy1);
        end
    endtask

    task automatic send_frame(input int npix, input bit gaps);
        fval = 1'b1;
        for (int i = 0; i < npix; i++) begin
            if (gaps && i > 0 && $urandom_range(3) == 0) begin
                dval = 1'b0;
                r = PW'($urandom_range(4095));
                g = PW'($urandom_range(4095));
                b = PW'($urandom_range(4095));
                step();
            end
            dval = 1'b1;
            r = PW'(pr[i]);
            g = PW'(pg[i]);
            b = PW'(pb[i]);
            step();
        end
        fval = 1'b0;
        dval = 1'b0;
        step();
    endtask

    task automatic check_stream(input string name, input int done_at);
        int t;
        t = 0;
        while (valid1 !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        checks++;
        if (valid1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_rise: got valid %b want 1 within 40 cycles",
                     name, valid1);
        end
        checks++;
        if (valid0 !== 1'b1 || seq1 !== 1'b0 || seq0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_first: got v0=%b s1=%b s0=%b want 1 0 0",
                     name, valid0, seq1, seq0);
        end
        for (int k = 0; k < N; k++) begin
            done = (k == done_at);
            step();
            done = 1'b0;
            checks++;
            if (seq1 !== exp1[k] || seq0 !== exp0[k] || valid1 !== 1'b1) begin
                errors++;
                $display("FAIL %s_bit%0d: got s1=%b s0=%b v=%b want %b %b 1",
                         name, k, seq1, seq0, valid1, exp1[k], exp0[k]);
            end
        end
        step();
        checks++;
        if (seq1 !== 1'b0 || seq0 !== 1'b0 || valid1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_tail: got s1=%b s0=%b v=%b busy=%b want 0 0 1 1",
                     name, seq1, seq0, valid1, busy1);
        end
    endtask

    task automatic finish_done(input string name);
        repeat (5) step();
        checks++;
        if (valid1 !== 1'b1 || seq1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got v=%b s=%b want 1 0", name, valid1, seq1);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (valid1 !== 1'b0 || valid0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got v1=%b v0=%b busy=%b want 0 0 0",
                     name, valid1, valid0, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (valid1 !== 0 || seq1 !== 0 || busy1 !== 0 || err1 !== 0 ||
            valid0 !== 0 || busy0 !== 0 || err0 !== 0) begin
            errors++;
            $display("FAIL reset: got v=%b s=%b busy=%b err=%b want 0 0 0 0",
                     valid1, seq1, busy1, err1);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 64; i++) begin
            pr[i] = (i % 2 == 0) ? 0 : 4095;
            pg[i] = pr[i];
            pb[i] = pr[i];
        end
        do_start(32'h400);
        calc_exp();
        send_frame(N, 1'b0);
        check_stream("alt", -1);
        finish_done("alt");
    endtask

    task automatic test_short_frame();
        fill_random();
        do_start($urandom_range(4095));
        send_frame(20, 1'b1);
        step();
        checks++;
        if (err1 !== 1'b1 || err0 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL short_err: got err=%b v=%b busy=%b want 1 0 1",
                     err1, valid1, busy1);
        end
        fill_random();
        calc_exp();
        send_frame(N, 1'b1);
        check_stream("retry", -1);
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky: got %b want 1", err1);
        end
        finish_done("retry");
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL short_idle_err: got %b want 1", err1);
        end
        fill_random();
        do_start($urandom_range(4095));
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL short_clear: got %b want 0", err1);
        end
        calc_exp();
        send_frame(N, 1'b0);
        check_stream("after_clear", -1);
        finish_done("after_clear");
    endtask

    task automatic test_equality();
        fill_random();
        pr[0] = 32'h400; pg[0] = 32'h400; pb[0] = 32'h400;
        pr[1] = 32'h800; pg[1] = 32'h800; pb[1] = 32'h800;
        pr[2] = 32'h401; pg[2] = 32'h400; pb[2] = 32'h3FF;
        do_start(32'h400);
        calc_exp();
        send_frame(N, 1'b1);
        check_stream("equal", -1);
        finish_done("equal");
    endtask

    task automatic test_fval_high();
        fval = 1'b1;
        for (int i = 0; i < 40; i++) begin
            dval = 1'b1;
            r = PW'($urandom_range(4095));
            g = PW'($urandom_range(4095));
            b = PW'($urandom_range(4095));
            if (i == 5) begin
                do_start($urandom_range(4095));
            end else begin
                step();
            end
        end
        fval = 1'b0;
        dval = 1'b0;
        step();
        fill_random();
        calc_exp();
        send_frame(40, 1'b1);
        check_stream("late", -1);
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL late_err: got %b want 0", err1);
        end
        finish_done("late");
    endtask

    task automatic test_done_in_stream();
        fill_random();
        do_start($urandom_range(4095));
        calc_exp();
        send_frame(N, 1'b1);
        check_stream("early_done", 10);
        finish_done("early_done");
    endtask

    task automatic test_reset_mid_stream();
        int t;
        fill_random();
        do_start($urandom_range(4095));
        send_frame(N, 1'b0);
        t = 0;
        while (valid1 !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid1 !== 0 || seq1 !== 0 || busy1 !== 0 || valid0 !== 0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b s=%b busy=%b want 0 0 0",
                     valid1, seq1, busy1);
        end
        step();
        rst_n = 1'b1;
        step();
        fill_random();
        do_start($urandom_range(4095));
        calc_exp();
        send_frame(N, 1'b1);
        check_stream("post_reset", -1);
        finish_done("post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            do_start($urandom_range(4095));
            calc_exp();
            send_frame(N, 1'b1);
            check_stream("rand", -1);
            finish_done("rand");
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_short_frame();
        test_equality();
        test_fval_high();
        test_done_in_stream();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
